// File: rtl/alu_pkg.sv
// Shared constants for the ALU-control stage: operation codes, funct/alu_op encodings
// and the mult/div sequencer state encoding.
package alu_pkg;

    localparam int ALU_CTRL_W = 4;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_SLTU = 4'b1111;

    localparam logic [1:0] AOP_ADD   = 2'b00;
    localparam logic [1:0] AOP_SUB   = 2'b01;
    localparam logic [1:0] AOP_RTYPE = 2'b10;
    localparam logic [1:0] AOP_OR    = 2'b11;

    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;

    typedef logic [1:0] seq_state_t;
    localparam seq_state_t SEQ_IDLE = 2'd0;
    localparam seq_state_t SEQ_RUN  = 2'd1;
    localparam seq_state_t SEQ_FIX  = 2'd2;

endpackage

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer (one shift-add or restoring-subtract step per cycle)
// that owns the HI/LO registers.
module muldiv_seq
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic              mthi,
    input  logic              mtlo,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    output logic              busy,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam int ACC_W = 2 * DATA_W + 1;

    seq_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic              div_q, div_d;
    logic              neg_lo_q, neg_lo_d;
    logic              neg_hi_q, neg_hi_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;

    logic              a_neg, b_neg;
    logic [DATA_W-1:0] a_mag, b_mag;
    logic [DATA_W:0]   mul_sum, div_diff;
    logic [ACC_W-1:0]  mul_next, div_sh, div_next;
    logic [2*DATA_W-1:0] prod;

    // acc holds {upper partial product, multiplier} for mult and {remainder, quotient} for div
    always_comb begin
        a_neg    = !op[0] && rs_val[DATA_W-1];
        b_neg    = !op[0] && rt_val[DATA_W-1];
        a_mag    = a_neg ? -rs_val : rs_val;
        b_mag    = b_neg ? -rt_val : rt_val;
        mul_sum  = acc_q[ACC_W-1:DATA_W] + (acc_q[0] ? {1'b0, b_q} : '0);
        mul_next = {1'b0, mul_sum, acc_q[DATA_W-1:1]};
        div_sh   = {acc_q[ACC_W-2:0], 1'b0};
        div_diff = div_sh[ACC_W-1:DATA_W] - {1'b0, b_q};
        div_next = div_diff[DATA_W] ? div_sh : {div_diff, div_sh[DATA_W-1:1], 1'b1};
        prod     = neg_lo_q ? -acc_q[2*DATA_W-1:0] : acc_q[2*DATA_W-1:0];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        b_d      = b_q;
        div_d    = div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        if (mthi) hi_d = rs_val;
        if (mtlo) lo_d = rs_val;
        case (state_q)
            SEQ_IDLE: begin
                if (start) begin
                    div_d    = op[1];
                    b_d      = b_mag;
                    cnt_d    = CNT_W'(DATA_W - 1);
                    neg_lo_d = a_neg ^ b_neg;
                    neg_hi_d = op[1] && a_neg;
                    if (op[1] && (rt_val == '0)) begin
                        // FIX then reads quotient = all-ones, remainder = dividend
                        acc_d    = {1'b0, rs_val, {DATA_W{1'b1}}};
                        neg_lo_d = 1'b0;
                        neg_hi_d = 1'b0;
                        cnt_d    = '0;
                        state_d  = SEQ_FIX;
                    end else begin
                        acc_d   = {{(DATA_W + 1){1'b0}}, a_mag};
                        state_d = SEQ_RUN;
                    end
                end
            end
            SEQ_RUN: begin
                acc_d = div_q ? div_next : mul_next;
                if (cnt_q == '0) begin
                    state_d = SEQ_FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SEQ_FIX: begin
                if (div_q) begin
                    lo_d = neg_lo_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
                    hi_d = neg_hi_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
                end else begin
                    hi_d = prod[2*DATA_W-1:DATA_W];
                    lo_d = prod[DATA_W-1:0];
                end
                state_d = SEQ_IDLE;
            end
            default: state_d = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= SEQ_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            b_q      <= '0;
            div_q    <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            div_q    <= div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy = (state_q != SEQ_IDLE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: rtl/alu_control_md.sv
// ALU-control stage: decodes alu_op/funct into a registered 4-bit ALU code, stalls HI/LO
// instructions while the mult/div sequencer is busy.
module alu_control_md
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = ALU_CTRL_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [1:0]        alu_op,
    input  logic [5:0]        funct,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    output logic              stall,
    output logic              out_valid,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic              illegal,
    output logic              busy,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    logic [3:0]        code_d;
    logic              illegal_d;
    logic              hilo_grp;
    logic              accept;
    logic              seq_start;
    logic              seq_mthi;
    logic              seq_mtlo;
    logic              out_valid_q;
    logic [CTRL_W-1:0] alu_ctrl_q;
    logic              illegal_q;

    always_comb begin
        code_d    = ALU_ADD;
        illegal_d = 1'b0;
        case (alu_op)
            AOP_ADD: code_d = ALU_ADD;
            AOP_SUB: code_d = ALU_SUB;
            AOP_OR:  code_d = ALU_OR;
            AOP_RTYPE: begin
                casez (funct)
                    F_ADD, F_ADDU:        code_d = ALU_ADD;
                    F_SUB, F_SUBU:        code_d = ALU_SUB;
                    F_AND:                code_d = ALU_AND;
                    F_OR:                 code_d = ALU_OR;
                    F_XOR:                code_d = ALU_XOR;
                    F_NOR:                code_d = ALU_NOR;
                    F_SLT:                code_d = ALU_SLT;
                    F_SLTU:               code_d = ALU_SLTU;
                    F_SLL:                code_d = ALU_SLL;
                    F_SRL:                code_d = ALU_SRL;
                    F_SRA:                code_d = ALU_SRA;
                    6'b0100??, 6'b0110??: code_d = ALU_ADD;
                    default:              illegal_d = 1'b1;
                endcase
            end
            default: code_d = ALU_ADD;
        endcase
    end

    // 0100xx (mfhi/mthi/mflo/mtlo) and 0110xx (mult/div) all touch HI/LO
    assign hilo_grp  = (alu_op == AOP_RTYPE) && (funct[5:4] == 2'b01) && !funct[2];
    assign stall     = in_valid && busy && hilo_grp;
    assign accept    = in_valid && !stall;
    assign seq_start = accept && hilo_grp && funct[3];
    assign seq_mthi  = accept && hilo_grp && (funct == F_MTHI);
    assign seq_mtlo  = accept && hilo_grp && (funct == F_MTLO);

    muldiv_seq #(
        .DATA_W (DATA_W)
    ) u_muldiv_seq (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (seq_start),
        .op      (funct[1:0]),
        .mthi    (seq_mthi),
        .mtlo    (seq_mtlo),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            alu_ctrl_q  <= CTRL_W'(ALU_ADD);
            illegal_q   <= 1'b0;
        end else begin
            out_valid_q <= accept;
            illegal_q   <= accept && illegal_d;
            if (accept) alu_ctrl_q <= CTRL_W'(code_d);
        end
    end

    assign out_valid = out_valid_q;
    assign alu_ctrl  = alu_ctrl_q;
    assign illegal   = illegal_q;

endmodule
